// File: rtl/cnt_capture_pkg.sv
// Shared definitions for the terminal-count capture block: register map,
// STATUS/CTRL field positions and the overflow counter width.
package cnt_capture_pkg;

  // Register index taken from addr[3:2]; byte offsets are 0x0, 0x4, 0x8, 0xC.
  typedef enum logic [1:0] {
    RegData   = 2'd0,
    RegStatus = 2'd1,
    RegCtrl   = 2'd2,
    RegOvfCnt = 2'd3
  } reg_e;

  // STATUS fields
  localparam int unsigned StatusCountLsb = 0;
  localparam int unsigned StatusCountW   = 5;
  localparam int unsigned StatusEmptyBit = 8;
  localparam int unsigned StatusFullBit  = 9;
  localparam int unsigned StatusOvfBit   = 10;

  // CTRL fields
  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlIrqEnBit = 1;
  localparam int unsigned CtrlFlushBit = 2;
  localparam int unsigned CtrlWmLsb    = 4;
  localparam int unsigned CtrlWmW      = 4;

  localparam int unsigned OvfCntW = 8;

  localparam int unsigned TsWDefault = 32;
  typedef logic [TsWDefault-1:0] ts_t;

  // A watermark of 0 behaves like 1: any pending entry is enough.
  function automatic logic [CtrlWmW-1:0] wm_threshold(input logic [CtrlWmW-1:0] wm);
    return (wm == '0) ? CtrlWmW'(1) : wm;
  endfunction

endpackage

// File: rtl/cnt_capture_fifo.sv
// Synchronous FIFO for captured timestamps. Flush overrides push and pop;
// push while full is accepted only when a pop happens in the same cycle.
module cnt_capture_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [Width-1:0]             wdata_i,
  output logic [Width-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i & ~flush_i & ~empty_o;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  // Pointer and occupancy tracking; pointers wrap naturally (Depth is a power of two).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage array; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cnt_tc_capture.sv
// Timestamps rising edges of the counter's terminal count, buffers them in a
// FIFO drained over a single-cycle OBI-style slave, and raises a level irq.
// Optional watermark interrupt threshold (CTRL[7:4]): CNT_CAPTURE_WATERMARK_EN.
module cnt_tc_capture
  import cnt_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tc_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [TS_W-1:0]    ts_q;
  logic               tc_q;
  logic               en_q, en_d;
  logic               irq_en_q, irq_en_d;
  logic               ovf_q, ovf_d;
  logic [OvfCntW-1:0] ovf_cnt_q, ovf_cnt_d;
  logic               rvalid_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q, irq_d;

  logic [TS_W-1:0]    fifo_head;
  logic               fifo_full, fifo_empty;
  logic [CntW-1:0]    fifo_count, count_nxt;

  reg_e               reg_sel;
  logic               wr_full, rd_req;
  logic               tc_evt, flush, pop, push, ovf_evt;
  logic [31:0]        status_word, ctrl_word;
  logic               unused_bits;

`ifdef CNT_CAPTURE_WATERMARK_EN
  logic [CtrlWmW-1:0] wm_q, wm_d;
`endif

  assign unused_bits = ^{addr_i[1:0], wdata_i};

  assign gnt_o    = req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign irq_o    = irq_q;

  assign reg_sel = reg_e'(addr_i[3:2]);
  assign wr_full = req_i & we_i & (be_i == 4'hF);
  assign rd_req  = req_i & ~we_i;

  // Reading an empty DATA register returns 0 and must not pop.
  assign tc_evt  = tc_i & ~tc_q & en_q;
  assign flush   = wr_full & (reg_sel == RegCtrl) & wdata_i[CtrlFlushBit];
  assign pop     = rd_req & (reg_sel == RegData) & ~fifo_empty;
  assign push    = tc_evt & ~flush & (~fifo_full | pop);
  assign ovf_evt = tc_evt & ~flush & fifo_full & ~pop;

  assign count_nxt = flush ? '0 : (fifo_count + CntW'(push) - CntW'(pop));

  cnt_capture_fifo #(
    .Depth (DEPTH),
    .Width (TS_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (ts_q),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Free-running timestamp and terminal-count edge history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q <= '0;
      tc_q <= 1'b0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      tc_q <= tc_i;
    end
  end

  // Control and overflow next state; a clear beats a simultaneous overflow.
  always_comb begin
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    ovf_d     = ovf_q;
    ovf_cnt_d = ovf_cnt_q;
    if (wr_full && reg_sel == RegCtrl) begin
      en_d     = wdata_i[CtrlEnBit];
      irq_en_d = wdata_i[CtrlIrqEnBit];
    end
    if (wr_full && reg_sel == RegStatus && wdata_i[StatusOvfBit]) begin
      ovf_d = 1'b0;
    end else if (ovf_evt) begin
      ovf_d = 1'b1;
    end
    if (wr_full && reg_sel == RegOvfCnt) begin
      ovf_cnt_d = '0;
    end else if (ovf_evt && ovf_cnt_q != '1) begin
      ovf_cnt_d = ovf_cnt_q + OvfCntW'(1);
    end
  end

`ifdef CNT_CAPTURE_WATERMARK_EN
  // Watermark field update.
  always_comb begin
    wm_d = wm_q;
    if (wr_full && reg_sel == RegCtrl) wm_d = wdata_i[CtrlWmLsb +: CtrlWmW];
  end

  // Watermark register.
  always_ff @(posedge clk_i) begin
    if (rst_i) wm_q <= '0;
    else       wm_q <= wm_d;
  end

  // Interrupt tracks the post-update occupancy against the watermark.
  always_comb begin
    irq_d = irq_en_d & (32'(count_nxt) >= 32'(wm_threshold(wm_d)));
  end
`else
  // Interrupt tracks the post-update occupancy.
  always_comb begin
    irq_d = irq_en_d & (count_nxt != '0);
  end
`endif

  // Read mux; all reads see the state before this cycle's side effects.
  always_comb begin
    status_word = '0;
    status_word[StatusCountLsb +: StatusCountW] = StatusCountW'(fifo_count);
    status_word[StatusEmptyBit] = fifo_empty;
    status_word[StatusFullBit]  = fifo_full;
    status_word[StatusOvfBit]   = ovf_q;
    ctrl_word = '0;
    ctrl_word[CtrlEnBit]    = en_q;
    ctrl_word[CtrlIrqEnBit] = irq_en_q;
`ifdef CNT_CAPTURE_WATERMARK_EN
    ctrl_word[CtrlWmLsb +: CtrlWmW] = wm_q;
`endif
    rdata_d = '0;
    if (rd_req) begin
      unique case (reg_sel)
        RegData:   rdata_d = fifo_empty ? 32'd0 : 32'(fifo_head);
        RegStatus: rdata_d = status_word;
        RegCtrl:   rdata_d = ctrl_word;
        RegOvfCnt: rdata_d = 32'(ovf_cnt_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  // Registered control state, bus response and interrupt.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
      rvalid_q  <= req_i;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_cnt_tc_capture.sv
// Self-checking bench for cnt_tc_capture: directed scenarios plus random bus
// and terminal-count traffic, compared against a queue-based reference model.
module tb_cnt_tc_capture;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TS_W  = 8;
  localparam int unsigned TsMod = 1 << TS_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tc = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt_o, rvalid_o, irq_o;
  logic [31:0] rdata_o;

  always #5 clk = ~clk;

  cnt_tc_capture #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) u_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .tc_i     (tc),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .be_i     (be),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .irq_o    (irq_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int unsigned m_ts;
  logic        m_tcp;
  int unsigned m_q[$];
  logic        m_en, m_ien, m_ovf;
  int unsigned m_wm, m_ovc;
  logic        e_rvalid, e_irq;
  logic [31:0] e_rdata;

  logic        tc_lvl = 1'b0;
  int unsigned exp_ts[6];
  int unsigned exp_new;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_cycle(input logic r, input logic t, input logic rq, input logic w,
                             input logic [3:0] a, input logic [31:0] wd, input logic [3:0] b);
    logic [1:0]  sel;
    logic        wrf, rdn, evt, fl, ovfe;
    int unsigned thr;
    if (r) begin
      m_ts = 0; m_tcp = 1'b0; m_q.delete();
      m_en = 1'b0; m_ien = 1'b0; m_ovf = 1'b0; m_wm = 0; m_ovc = 0;
      e_rvalid = 1'b0; e_rdata = '0; e_irq = 1'b0;
    end else begin
      sel  = a[3:2];
      wrf  = rq && w && (b == 4'hF);
      rdn  = rq && !w;
      evt  = t && !m_tcp && m_en;
      fl   = wrf && sel == 2'd2 && wd[2];
      ovfe = 1'b0;
      e_rdata = '0;
      if (rdn) begin
        case (sel)
          2'd0: e_rdata = (m_q.size() > 0) ? m_q[0] : 32'd0;
          2'd1: begin
            e_rdata     = 32'(m_q.size());
            e_rdata[8]  = (m_q.size() == 0);
            e_rdata[9]  = (m_q.size() == int'(DEPTH));
            e_rdata[10] = m_ovf;
          end
          2'd2: e_rdata = {24'd0, 4'(m_wm), 2'b00, m_ien, m_en};
          default: e_rdata = m_ovc;
        endcase
      end
      if (fl) begin
        m_q.delete();
      end else begin
        if (rdn && sel == 2'd0 && m_q.size() > 0) void'(m_q.pop_front());
        if (evt) begin
          if (m_q.size() < int'(DEPTH)) m_q.push_back(m_ts);
          else ovfe = 1'b1;
        end
      end
      if (wrf && sel == 2'd3) m_ovc = 0;
      else if (ovfe && m_ovc < 255) m_ovc++;
      if (wrf && sel == 2'd1 && wd[10]) m_ovf = 1'b0;
      else if (ovfe) m_ovf = 1'b1;
      if (wrf && sel == 2'd2) begin
        m_en  = wd[0];
        m_ien = wd[1];
`ifdef CNT_CAPTURE_WATERMARK_EN
        m_wm  = int'(wd[7:4]);
`endif
      end
      m_ts     = (m_ts + 1) % TsMod;
      m_tcp    = t;
      e_rvalid = rq;
      thr      = (m_wm == 0) ? 1 : m_wm;
      e_irq    = m_ien && (m_q.size() >= int'(thr));
    end
  endtask

  // One clock cycle: drive at negedge, check outputs just after the posedge.
  task automatic step(input logic r, input logic t, input logic rq, input logic w,
                      input logic [3:0] a, input logic [31:0] wd, input logic [3:0] b);
    @(negedge clk);
    rst = r; tc = t; req = rq; we = w; addr = a; wdata = wd; be = b;
    #1;
    check_eq("gnt", 32'(gnt_o), 32'(rq));
    model_cycle(r, t, rq, w, a, wd, b);
    @(posedge clk);
    #1;
    check_eq("rvalid", 32'(rvalid_o), 32'(e_rvalid));
    check_eq("rdata", rdata_o, e_rdata);
    check_eq("irq", 32'(irq_o), 32'(e_irq));
  endtask

  task automatic idle();
    step(1'b0, tc_lvl, 1'b0, 1'b0, 4'h0, 32'd0, 4'h0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b0, tc_lvl, 1'b1, 1'b0, a, 32'd0, 4'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    step(1'b0, tc_lvl, 1'b1, 1'b1, a, d, b);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, tc_lvl, 1'b0, 1'b0, 4'h0, 32'd0, 4'h0);
  endtask

  initial begin
    // Reset, then first capture at cycle 10
    do_reset(3);
    check_eq("rst_rvalid", 32'(rvalid_o), 32'd0);
    check_eq("rst_irq", 32'(irq_o), 32'd0);
    idle();
    idle();
    wr(4'h8, 32'h3, 4'hF);
    for (int i = 0; i < 7; i++) idle();
    tc_lvl = 1'b1;
    idle();
    check_eq("tp1_irq_on", 32'(irq_o), 32'd1);
    rd(4'h4);
    check_eq("tp1_status", rdata_o, 32'h1);
    rd(4'h0);
    check_eq("tp1_data", rdata_o, 32'd10);
    check_eq("tp1_irq_off", 32'(irq_o), 32'd0);
    rd(4'h4);
    check_eq("tp1_single_evt", rdata_o, 32'h100);
    tc_lvl = 1'b0;
    idle();

    // Six pulses into a four-deep FIFO
    for (int i = 0; i < 6; i++) begin
      tc_lvl = 1'b1;
      exp_ts[i] = m_ts;
      idle();
      tc_lvl = 1'b0;
      idle();
    end
    rd(4'h4);
    check_eq("tp2_status", rdata_o, 32'h604);
    rd(4'hC);
    check_eq("tp2_ovfcnt", rdata_o, 32'd2);

    // Edge while full coinciding with a DATA read
    tc_lvl = 1'b1;
    exp_new = m_ts;
    rd(4'h0);
    check_eq("tp3_head", rdata_o, exp_ts[0]);
    tc_lvl = 1'b0;
    rd(4'h4);
    check_eq("tp3_status", rdata_o, 32'h604);
    rd(4'hC);
    check_eq("tp3_ovfcnt", rdata_o, 32'd2);
    for (int i = 1; i < 4; i++) begin
      rd(4'h0);
      check_eq("tp2_order", rdata_o, exp_ts[i]);
    end
    rd(4'h0);
    check_eq("tp3_pushed", rdata_o, exp_new);
    rd(4'h4);
    check_eq("tp2_drained", rdata_o, 32'h500);

    // Flush coinciding with an edge
    wr(4'h4, 32'h400, 4'hF);
    wr(4'hC, 32'h0, 4'hF);
    tc_lvl = 1'b1;
    wr(4'h8, 32'h7, 4'hF);
    tc_lvl = 1'b0;
    check_eq("tp4_irq", 32'(irq_o), 32'd0);
    rd(4'h4);
    check_eq("tp4_status", rdata_o, 32'h100);
    rd(4'hC);
    check_eq("tp4_ovfcnt", rdata_o, 32'd0);
    rd(4'h0);
    check_eq("tp4_data", rdata_o, 32'd0);

    // Partial byte-enable write is ignored
    wr(4'h8, 32'h0, 4'h3);
    rd(4'h8);
    check_eq("be_ignored", rdata_o, 32'h3);

    // Timestamp wrap at 8 bits: events at 255 and 2
    for (int k = 0; k < 300 && m_ts != 255; k++) idle();
    tc_lvl = 1'b1; idle();
    tc_lvl = 1'b0; idle();
    idle();
    tc_lvl = 1'b1; idle();
    tc_lvl = 1'b0;
    rd(4'h0);
    check_eq("wrap_first", rdata_o, 32'd255);
    rd(4'h0);
    check_eq("wrap_second", rdata_o, 32'd2);

`ifdef CNT_CAPTURE_WATERMARK_EN
    // Watermark of 3
    wr(4'h8, 32'h37, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tc_lvl = 1'b1;
      idle();
      check_eq("wm_irq", 32'(irq_o), (i == 2) ? 32'd1 : 32'd0);
      tc_lvl = 1'b0;
      idle();
    end
    wr(4'h8, 32'h7, 4'hF);
`endif

    // Reset in the middle of a burst
    for (int i = 0; i < 2; i++) begin
      tc_lvl = 1'b1; idle();
      tc_lvl = 1'b0; idle();
    end
    tc_lvl = 1'b1;
    do_reset(1);
    tc_lvl = 1'b0;
    rd(4'h4);
    check_eq("rst_empty", rdata_o, 32'h100);
    wr(4'h8, 32'h3, 4'hF);
    tc_lvl = 1'b1; idle();
    tc_lvl = 1'b0;
    rd(4'h0);
    check_eq("rst_ts", rdata_o, 32'd2);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic        r, t, rq, w;
      logic [3:0]  a, b;
      logic [31:0] wd;
      r  = ($urandom_range(0, 299) == 0);
      t  = ($urandom_range(0, 2) == 0);
      rq = 1'($urandom_range(0, 1));
      w  = ($urandom_range(0, 3) == 0);
      a  = 4'($urandom);
      wd = $urandom;
      if ($urandom_range(0, 5) != 0) wd[2] = 1'b0;
      if (a[3:2] == 2'd2 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      b  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      step(r, t, rq, w, a, wd, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
